switch_allocator: RTL and testbench

- Shares each router output port among the input ports, with one round-robin arbiter per output.
- Sits between the per-input route computation stage, which supplies a 3-bit output-port code per head flit, and the crossbar.
- Implements wormhole locking: once an input wins an output, it holds it until its tail flit transfers.
- Drives crossbar select codes and per-input flit-accept strobes.

---
 rtl/switch_allocator_pkg.sv | 21 ++
 rtl/switch_allocator_if.sv | 24 ++
 rtl/switch_allocator_rr_arbiter.sv | 28 ++
 rtl/switch_allocator.sv | 105 ++++++++++
 tb/tb_switch_allocator.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_allocator_pkg.sv
// Shared NoC router definitions: port codes, default sizes and a flattened-bus field helper.
// The route computation stage uses the same port codes.
package switch_allocator_pkg;

    localparam int NPORTS = 5;
    localparam int PSIZE  = 3;

    typedef enum logic [PSIZE-1:0] {
        PORT_L = 3'd0,
        PORT_N = 3'd1,
        PORT_E = 3'd2,
        PORT_S = 3'd3,
        PORT_W = 3'd4
    } port_e;

    function automatic logic [PSIZE-1:0] port_field(input logic [NPORTS*PSIZE-1:0] flat,
                                                    input int idx);
        return flat[idx*PSIZE +: PSIZE];
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers, the switch allocator and the crossbar.
interface switch_allocator_if #(
    parameter int NPORTS = 5,
    parameter int PSIZE  = 3
) ();
    logic [NPORTS-1:0]       req_valid;
    logic [NPORTS*PSIZE-1:0] req_port;
    logic [NPORTS-1:0]       req_tail;
    logic [NPORTS-1:0]       out_ready;
    logic [NPORTS-1:0]       grant;
    logic [NPORTS-1:0]       out_valid;
    logic [NPORTS*PSIZE-1:0] xbar_sel;
    logic [NPORTS-1:0]       err_bad_port;

    modport master (
        output req_valid, req_port, req_tail, out_ready,
        input  grant, out_valid, xbar_sel, err_bad_port
    );

    modport slave (
        input  req_valid, req_port, req_tail, out_ready,
        output grant, out_valid, xbar_sel, err_bad_port
    );
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo N for the first request.
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    int  cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = W'(cand);
            end
        end
    end
endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking for an NPORTS-port router.
//
// state  | meaning
// IDLE   | output free; arbitrate among requesters, lock winner next cycle
// LOCKED | output owned by owner[o]; flits transfer until the tail goes through
module switch_allocator #(
    parameter int NPORTS = switch_allocator_pkg::NPORTS,
    parameter int PSIZE  = switch_allocator_pkg::PSIZE
) (
    input  logic              clk,
    input  logic              reset,
    switch_allocator_if.slave bus
);
    import switch_allocator_pkg::*;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]        state  [NPORTS];
    logic [PSIZE-1:0]  owner  [NPORTS];
    logic [PSIZE-1:0]  rr_ptr [NPORTS];
    logic [NPORTS-1:0] err;

    logic [PSIZE-1:0]  req_code [NPORTS];
    logic [NPORTS-1:0] bad_code;
    logic [NPORTS-1:0] cand     [NPORTS];
    logic [NPORTS-1:0] win_gnt  [NPORTS];
    logic [PSIZE-1:0]  win_idx  [NPORTS];
    logic [NPORTS-1:0] xfer;
    logic [NPORTS-1:0] tail_xfer;

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            req_code[i] = port_field(bus.req_port, i);
            bad_code[i] = (req_code[i] >= PSIZE'(NPORTS));
        end
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                cand[o][i] = bus.req_valid[i] && (req_code[i] == PSIZE'(o));
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rr_arbiter #(.N(NPORTS), .W(PSIZE)) u_arb (
            .req (cand[o]),
            .ptr (rr_ptr[o]),
            .gnt (win_gnt[o]),
            .idx (win_idx[o])
        );
        assign bus.xbar_sel[o*PSIZE +: PSIZE] = owner[o];
    end

    // Grants come straight from the lock state so a locked output moves a flit every ready cycle.
    always_comb begin
        bus.grant     = '0;
        bus.out_valid = '0;
        xfer          = '0;
        tail_xfer     = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (state[o] == ST_LOCKED) begin
                bus.out_valid[o] = bus.req_valid[owner[o]];
                xfer[o]          = bus.req_valid[owner[o]] && bus.out_ready[o];
                tail_xfer[o]     = xfer[o] && bus.req_tail[owner[o]];
                if (xfer[o]) begin
                    bus.grant[owner[o]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < NPORTS; o++) begin
                state[o]  <= ST_IDLE;
                owner[o]  <= '0;
                rr_ptr[o] <= PSIZE'(NPORTS - 1);
            end
            err <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                case (state[o])
                    ST_IDLE: begin
                        if (|win_gnt[o]) begin
                            owner[o] <= win_idx[o];
                            state[o] <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        // The finishing owner becomes lowest priority for the next arbitration.
                        if (tail_xfer[o]) begin
                            state[o]  <= ST_IDLE;
                            rr_ptr[o] <= owner[o];
                        end
                    end
                    default: state[o] <= ST_IDLE;
                endcase
            end
            err <= err | (bus.req_valid & bad_code);
        end
    end

    assign bus.err_bad_port = err;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with a cycle-level reference model of ownership and priority.
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    localparam int NP = 5;
    localparam int PS = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    switch_allocator_if #(.NPORTS(NP), .PSIZE(PS)) bus ();
    switch_allocator #(.NPORTS(NP), .PSIZE(PS)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which outputs are held, by whom, and who was served last.
    bit  m_init = 1'b0;
    bit  m_locked [NP];
    int  m_owner  [NP];
    int  m_last   [NP];
    bit  m_err    [NP];

    always @(negedge clk) begin
        logic [NP-1:0]    eg, ev, ee;
        logic [NP*PS-1:0] ex;
        int  ow, c;
        bit  found;
        if (m_init) begin
            eg = '0; ev = '0; ee = '0; ex = '0;
            for (int o = 0; o < NP; o++) begin
                ex[o*PS +: PS] = PS'(m_owner[o]);
                if (m_locked[o]) begin
                    ow    = m_owner[o];
                    ev[o] = bus.req_valid[ow];
                    if (bus.req_valid[ow] && bus.out_ready[o]) eg[ow] = 1'b1;
                end
            end
            for (int i = 0; i < NP; i++) ee[i] = m_err[i];
            check("model_grant",     32'(bus.grant),        32'(eg));
            check("model_out_valid", 32'(bus.out_valid),    32'(ev));
            check("model_xbar_sel",  32'(bus.xbar_sel),     32'(ex));
            check("model_err",       32'(bus.err_bad_port), 32'(ee));
        end
        if (reset) begin
            for (int o = 0; o < NP; o++) begin
                m_locked[o] = 1'b0; m_owner[o] = 0; m_last[o] = NP - 1; m_err[o] = 1'b0;
            end
            m_init = 1'b1;
        end else if (m_init) begin
            for (int o = 0; o < NP; o++) begin
                if (m_locked[o]) begin
                    ow = m_owner[o];
                    if (bus.req_valid[ow] && bus.out_ready[o] && bus.req_tail[ow]) begin
                        m_locked[o] = 1'b0;
                        m_last[o]   = ow;
                    end
                end else begin
                    found = 1'b0;
                    for (int k = 1; k <= NP; k++) begin
                        c = (m_last[o] + k) % NP;
                        if (!found && bus.req_valid[c] && int'(bus.req_port[c*PS +: PS]) == o) begin
                            found = 1'b1; m_locked[o] = 1'b1; m_owner[o] = c;
                        end
                    end
                end
            end
            for (int i = 0; i < NP; i++)
                if (bus.req_valid[i] && int'(bus.req_port[i*PS +: PS]) >= NP) m_err[i] = 1'b1;
        end
    end

    // Traffic driver: rem[i] flits left in input i's current packet, dst[i] its output code.
    int  rem [NP];
    int  dst [NP];
    bit  hold [NP];
    logic [NP-1:0] ready;
    int  gcount [NP];
    int  first_g [NP];
    int  last_g [NP];
    int  step_no;
    logic [NP-1:0]    g_last, ov_last, err_last;
    logic [NP*PS-1:0] xs_last;

    task automatic clear_traffic();
        for (int i = 0; i < NP; i++) begin
            rem[i] = 0; dst[i] = 0; hold[i] = 1'b0;
            gcount[i] = 0; first_g[i] = -1; last_g[i] = -1;
        end
        ready   = '1;
        step_no = 0;
    endtask

    task automatic step();
        for (int i = 0; i < NP; i++) begin
            bus.req_valid[i]          = (rem[i] > 0) && !hold[i];
            bus.req_tail[i]           = (rem[i] == 1);
            bus.req_port[i*PS +: PS]  = PS'(dst[i]);
        end
        bus.out_ready = ready;
        #1;
        g_last   = bus.grant;
        ov_last  = bus.out_valid;
        xs_last  = bus.xbar_sel;
        err_last = bus.err_bad_port;
        for (int i = 0; i < NP; i++) begin
            if (g_last[i]) begin
                gcount[i]++;
                if (first_g[i] < 0) first_g[i] = step_no;
                last_g[i] = step_no;
                rem[i]--;
            end
        end
        @(posedge clk);
        #1;
        step_no++;
    endtask

    int gorder[$];
    int gsel[$];
    int gstep[$];

    initial begin
        bus.req_valid = '0; bus.req_port = '0; bus.req_tail = '0; bus.out_ready = '1;
        clear_traffic();

        // 1: reset then a single-flit packet 0 -> E
        step(); step();
        reset = 1'b0;
        check("rst_grant",     32'(bus.grant),        32'd0);
        check("rst_out_valid", 32'(bus.out_valid),    32'd0);
        check("rst_xbar_sel",  32'(bus.xbar_sel),     32'd0);
        check("rst_err",       32'(bus.err_bad_port), 32'd0);
        clear_traffic();
        rem[0] = 1; dst[0] = int'(PORT_E);
        step();
        check("t1_no_grant_idle", 32'(g_last), 32'd0);
        step();
        check("t1_grant0",     32'(g_last),              32'b00001);
        check("t1_out_valid2", 32'(ov_last),             32'b00100);
        check("t1_xbar2",      32'(xs_last[2*PS +: PS]), 32'd0);
        step();
        check("t1_idle_after", 32'(g_last | ov_last), 32'd0);

        // 2: round-robin on W among inputs 1, 3, 4
        clear_traffic();
        dst[1] = int'(PORT_W); dst[3] = int'(PORT_W); dst[4] = int'(PORT_W);
        for (int s = 0; s < 8; s++) begin
            rem[1] = 1; rem[3] = 1; rem[4] = 1;
            step();
            for (int i = 0; i < NP; i++) begin
                if (g_last[i]) begin
                    gorder.push_back(i);
                    gsel.push_back(int'(xs_last[4*PS +: PS]));
                    gstep.push_back(s);
                end
            end
        end
        rem[1] = 0; rem[3] = 0; rem[4] = 0;
        step(); step();
        check("t2_grant_count", 32'(gorder.size()), 32'd4);
        if (gorder.size() == 4) begin
            check("t2_order0", 32'(gorder[0]), 32'd1);
            check("t2_order1", 32'(gorder[1]), 32'd3);
            check("t2_order2", 32'(gorder[2]), 32'd4);
            check("t2_order3", 32'(gorder[3]), 32'd1);
            check("t2_sel1",   32'(gsel[1]),   32'd3);
            check("t2_sel2",   32'(gsel[2]),   32'd4);
            check("t2_step0",  32'(gstep[0]),  32'd1);
            check("t2_step3",  32'(gstep[3]),  32'd7);
        end

        // 3: wormhole lock, 4-flit packet 0 -> N with input 2 contending from the next cycle
        clear_traffic();
        rem[0] = 4; dst[0] = int'(PORT_N);
        step();
        rem[2] = 1; dst[2] = int'(PORT_N);
        for (int s = 0; s < 9; s++) step();
        check("t3_in0_flits",   32'(gcount[0]),  32'd4);
        check("t3_in0_tail",    32'(last_g[0]),  32'd4);
        check("t3_in2_first",   32'(first_g[2]), 32'd6);
        check("t3_in2_flits",   32'(gcount[2]),  32'd1);

        // 4: backpressure then bubble during a 3-flit packet 1 -> S
        clear_traffic();
        rem[1] = 3; dst[1] = int'(PORT_S);
        step();
        step();
        check("t4_flit1", 32'(g_last), 32'b00010);
        ready[3] = 1'b0;
        step();
        check("t4_bp_grant", 32'(g_last),     32'd0);
        check("t4_bp_valid", 32'(ov_last[3]), 32'd1);
        step();
        check("t4_bp_grant2", 32'(g_last), 32'd0);
        ready[3] = 1'b1;
        hold[1]  = 1'b1;
        step();
        check("t4_bubble_grant", 32'(g_last),              32'd0);
        check("t4_bubble_valid", 32'(ov_last[3]),          32'd0);
        check("t4_bubble_xbar",  32'(xs_last[3*PS +: PS]), 32'd1);
        hold[1] = 1'b0;
        for (int s = 0; s < 4; s++) step();
        check("t4_flits", 32'(gcount[1]), 32'd3);
        check("t4_tail",  32'(last_g[1]), 32'd6);

        // 5: parallel grants and an invalid code
        clear_traffic();
        rem[1] = 1; dst[1] = int'(PORT_L);
        rem[2] = 1; dst[2] = int'(PORT_S);
        rem[4] = 1; dst[4] = 6;
        step();
        check("t5_idle", 32'(g_last), 32'd0);
        step();
        check("t5_parallel", 32'(g_last),   32'b00110);
        check("t5_err_set",  32'(err_last), 32'b10000);
        rem[4] = 0;
        for (int s = 0; s < 3; s++) step();
        check("t5_err_sticky", 32'(err_last),  32'b10000);
        check("t5_no_grant4",  32'(gcount[4]), 32'd0);

        // 6: reset in the middle of a 4-flit packet 3 -> E
        clear_traffic();
        rem[3] = 4; dst[3] = int'(PORT_E);
        step(); step(); step();
        check("t6_pre_flits", 32'(gcount[3]), 32'd2);
        rem[3] = 0;
        reset  = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_grant", 32'(bus.grant),        32'd0);
        check("t6_rst_valid", 32'(bus.out_valid),    32'd0);
        check("t6_rst_xbar",  32'(bus.xbar_sel),     32'd0);
        check("t6_rst_err",   32'(bus.err_bad_port), 32'd0);
        clear_traffic();
        rem[0] = 1; dst[0] = int'(PORT_E);
        rem[3] = 1; dst[3] = int'(PORT_E);
        step();
        step();
        check("t6_fresh_winner", 32'(g_last), 32'b00001);
        for (int s = 0; s < 4; s++) step();
        check("t6_in3_after", 32'(first_g[3]), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
